// File: rtl/score_keeper.sv
// score_keeper: game-progress controller feeding the level parameter table.
// Counts hits, compares the running score against the table's max_points
// threshold, advances the level with an inter-level pause, and ends the game
// in a WON or LOST state.
//
// Optional feature macro: SCORE_LIVES_EN
//   defined   - misses consume lives; the last life lost ends the game.
//   undefined - any miss ends the game; lives reads a constant 3.
module score_keeper #(
  parameter int MAX_LEVEL    = 8,
  parameter int PAUSE_CYCLES = 100000000,
  parameter int LIVES        = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        hit,
  input  logic        miss,
  input  logic [31:0] max_points,
  output logic [3:0]  level,
  output logic [31:0] points,
  output logic [1:0]  lives,
  output logic        playing,
  output logic        level_up,
  output logic        game_won,
  output logic        game_over
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PLAY,
    S_PAUSE,
    S_WON,
    S_LOST
  } state_t;

  localparam logic [3:0]  LEVEL_FIRST = 4'd1;
  localparam logic [3:0]  LEVEL_LAST  = 4'(MAX_LEVEL);
  localparam logic [31:0] PAUSE_LAST  = 32'(PAUSE_CYCLES - 1);

`ifdef SCORE_LIVES_EN
  localparam logic [1:0]  LIVES_INIT  = 2'(LIVES);
`else
  // Without the lives feature the output is a fixed 3.
  localparam logic [1:0]  LIVES_INIT  = 2'd3;
`endif

  // Reject configurations the pause/lives logic cannot honour.
  if (PAUSE_CYCLES < 2 || LIVES < 1 || LIVES > 3 || MAX_LEVEL < 1 || MAX_LEVEL > 15) begin : g_param_check
    $error("score_keeper: parameter out of range");
  end

  state_t      state;
  logic [31:0] pause_cnt;
  logic [31:0] points_next;
  logic        threshold_hit;

  // Score after accepting the current hit, and whether it clears the level.
  assign points_next   = points + 32'd1;
  assign threshold_hit = (points_next >= max_points);

  // Game state machine; every output is a register updated here.
  // NOTE: asynchronous reset sits in the sensitivity list so it acts without a clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      pause_cnt <= '0;
      level     <= LEVEL_FIRST;
      points    <= '0;
      lives     <= LIVES_INIT;
      playing   <= 1'b0;
      level_up  <= 1'b0;
      game_won  <= 1'b0;
      game_over <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values;
      // level_up defaults low here and is raised only on the advancing cycle.
      level_up <= 1'b0;

      case (state)
        S_IDLE: begin
          if (start) begin
            state   <= S_PLAY;
            playing <= 1'b1;
          end
        end

        S_PLAY: begin
          if (miss) begin
            // A miss wins over a simultaneous hit; the hit is dropped.
`ifdef SCORE_LIVES_EN
            if (lives > 2'd1) begin
              lives <= lives - 2'd1;
            end else begin
              lives     <= 2'd0;
              state     <= S_LOST;
              playing   <= 1'b0;
              game_over <= 1'b1;
            end
`else
            state     <= S_LOST;
            playing   <= 1'b0;
            game_over <= 1'b1;
`endif
          end else if (hit) begin
            points <= points_next;
            if (threshold_hit) begin
              if (level == LEVEL_LAST) begin
                state    <= S_WON;
                playing  <= 1'b0;
                game_won <= 1'b1;
              end else begin
                level     <= level + 4'd1;
                level_up  <= 1'b1;
                state     <= S_PAUSE;
                playing   <= 1'b0;
                pause_cnt <= '0;
              end
            end
          end
        end

        S_PAUSE: begin
          // The pause also gives the level table time to present the new threshold.
          pause_cnt <= pause_cnt + 32'd1;
          if (pause_cnt == PAUSE_LAST) begin
            state   <= S_PLAY;
            playing <= 1'b1;
          end
        end

        S_WON, S_LOST: begin
          if (start) begin
            state     <= S_IDLE;
            pause_cnt <= '0;
            level     <= LEVEL_FIRST;
            points    <= '0;
            lives     <= LIVES_INIT;
            playing   <= 1'b0;
            game_won  <= 1'b0;
            game_over <= 1'b0;
          end
        end

        default: begin
          state   <= S_IDLE;
          playing <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_score_keeper.sv
// Testbench for score_keeper: randomized hit/miss/start stimulus, a behavioural
// game model, and a scoreboard queue drained by an independent monitor.
// A registered level table (8 points per level, or a flat 8) closes the loop.
module tb_score_keeper;

  localparam int MAX_LEVEL    = 8;
  localparam int PAUSE_CYCLES = 2;
  localparam int LIVES_P      = 3;

`ifdef SCORE_LIVES_EN
  localparam bit LIVES_EN    = 1'b1;
  localparam int LIVES_START = LIVES_P;
`else
  localparam bit LIVES_EN    = 1'b0;
  localparam int LIVES_START = 3;
`endif

  localparam int G_IDLE  = 0;
  localparam int G_PLAY  = 1;
  localparam int G_PAUSE = 2;
  localparam int G_WON   = 3;
  localparam int G_LOST  = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        hit = 1'b0;
  logic        miss = 1'b0;
  logic [31:0] max_points;
  logic [3:0]  level;
  logic [31:0] points;
  logic [1:0]  lives;
  logic        playing;
  logic        level_up;
  logic        game_won;
  logic        game_over;

  int checks = 0;
  int errors = 0;

  score_keeper #(
    .MAX_LEVEL   (MAX_LEVEL),
    .PAUSE_CYCLES(PAUSE_CYCLES),
    .LIVES       (LIVES_P)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .hit       (hit),
    .miss      (miss),
    .max_points(max_points),
    .level     (level),
    .points    (points),
    .lives     (lives),
    .playing   (playing),
    .level_up  (level_up),
    .game_won  (game_won),
    .game_over (game_over)
  );

  always #5 clk = ~clk;

  // Level table: 0 = flat threshold of 8, 1 = cumulative 8 points per level.
  int tbl_mode = 0;

  function automatic int table_points(int lvl, int mode);
    return (mode != 0) ? 8 * lvl : 8;
  endfunction

  // Registered table output, one cycle behind the DUT's level.
  always @(posedge clk) max_points <= 32'(table_points(int'(level), tbl_mode));

  // ---------------- behavioural model ----------------
  typedef struct {
    int level;
    int points;
    int lives;
    bit playing;
    bit level_up;
    bit won;
    bit over;
  } snap_t;

  snap_t exp_q[$];

  int m_mode, m_level, m_points, m_lives, m_pause_left, mp_cur;
  bit m_lu;
  int lu_model = 0;
  int lu_dut = 0;

  function automatic snap_t model_snap();
    snap_t s;
    s.level    = m_level;
    s.points   = m_points;
    s.lives    = m_lives;
    s.playing  = (m_mode == G_PLAY);
    s.level_up = m_lu;
    s.won      = (m_mode == G_WON);
    s.over     = (m_mode == G_LOST);
    return s;
  endfunction

  task automatic model_reset();
    m_mode       = G_IDLE;
    m_level      = 1;
    m_points     = 0;
    m_lives      = LIVES_START;
    m_pause_left = 0;
    m_lu         = 1'b0;
    mp_cur       = table_points(1, tbl_mode);
  endtask

  // One clock edge of the game rules; threshold seen is the table output of the previous level.
  task automatic model_step(bit st, bit h, bit m);
    int thr;
    thr    = mp_cur;
    mp_cur = table_points(m_level, tbl_mode);
    m_lu   = 1'b0;
    case (m_mode)
      G_IDLE: if (st) m_mode = G_PLAY;
      G_PLAY: begin
        if (m) begin
          if (LIVES_EN && m_lives > 1) m_lives = m_lives - 1;
          else begin
            if (LIVES_EN) m_lives = 0;
            m_mode = G_LOST;
          end
        end else if (h) begin
          m_points = m_points + 1;
          if (m_points >= thr) begin
            if (m_level == MAX_LEVEL) m_mode = G_WON;
            else begin
              m_level      = m_level + 1;
              m_lu         = 1'b1;
              m_mode       = G_PAUSE;
              m_pause_left = PAUSE_CYCLES;
            end
          end
        end
      end
      G_PAUSE: begin
        m_pause_left = m_pause_left - 1;
        if (m_pause_left == 0) m_mode = G_PLAY;
      end
      default: begin
        if (st) begin
          m_mode   = G_IDLE;
          m_level  = 1;
          m_points = 0;
          m_lives  = LIVES_START;
        end
      end
    endcase
    if (m_lu) lu_model++;
  endtask

  // ---------------- checking ----------------
  task automatic check(string name, int actual, int required);
    checks++;
    if (actual != required) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", name, actual, required, $time);
    end
  endtask

  // Monitor: after every edge, pop the expected response and compare all outputs.
  initial begin
    snap_t e;
    forever begin
      @(posedge clk);
      #1;
      if (level_up === 1'b1) lu_dut++;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (level !== 4'(e.level) || points !== 32'(e.points) || lives !== 2'(e.lives) ||
            playing !== e.playing || level_up !== e.level_up ||
            game_won !== e.won || game_over !== e.over) begin
          errors++;
          $display("FAIL outputs t=%0t actual lvl=%0d pts=%0d lives=%0d play=%b lu=%b won=%b over=%b required lvl=%0d pts=%0d lives=%0d play=%b lu=%b won=%b over=%b",
                   $time, level, points, lives, playing, level_up, game_won, game_over,
                   e.level, e.points, e.lives, e.playing, e.level_up, e.won, e.over);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  // Drive one cycle of inputs, predict the edge, queue the expectation.
  task automatic cycle(bit st, bit h, bit m);
    start = st;
    hit   = h;
    miss  = m;
    model_step(st, h, m);
    exp_q.push_back(model_snap());
    @(negedge clk);
    start = 1'b0;
    hit   = 1'b0;
    miss  = 1'b0;
  endtask

  // Assert reset between edges and confirm it takes effect without a clock.
  task automatic do_reset();
    rst_n = 1'b0;
    start = 1'b0;
    hit   = 1'b0;
    miss  = 1'b0;
    #1;
    check("rst_level", int'(level), 1);
    check("rst_points", int'(points), 0);
    check("rst_lives", int'(lives), LIVES_START);
    check("rst_playing", int'(playing), 0);
    check("rst_level_up", int'(level_up), 0);
    check("rst_game_won", int'(game_won), 0);
    check("rst_game_over", int'(game_over), 0);
    model_reset();
    repeat (3) begin
      exp_q.push_back(model_snap());
      @(negedge clk);
    end
    rst_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int lu_start;

    // Flat threshold of 8: eight hits advance to level 2, then a timed pause.
    tbl_mode = 0;
    @(negedge clk);
    do_reset();
    cycle(1'b1, 1'b0, 1'b0);
    check("start_playing", int'(playing), 1);
    for (int i = 0; i < 8; i++) cycle(1'b0, 1'b1, 1'b0);
    check("flat_level", int'(level), 2);
    check("flat_points", int'(points), 8);
    check("flat_level_up", int'(level_up), 1);
    check("flat_pause_low", int'(playing), 0);
    for (int i = 1; i < PAUSE_CYCLES; i++) begin
      cycle(1'b0, 1'b0, 1'b0);
      check("flat_pause_still_low", int'(playing), 0);
      check("flat_level_up_single", int'(level_up), 0);
    end
    cycle(1'b0, 1'b0, 1'b0);
    check("flat_play_resumes", int'(playing), 1);

    // Full game with the cumulative table; random hits, including during pauses.
    tbl_mode = 1;
    do_reset();
    lu_start = lu_dut;
    cycle(1'b1, 1'b0, 1'b0);
    n = 0;
    while (m_mode != G_WON && n < 3000) begin
      cycle(1'b0, $urandom_range(0, 99) < 70, 1'b0);
      n++;
    end
    cycle(1'b0, 1'b1, 1'b0);
    check("won_flag", int'(game_won), 1);
    check("won_level", int'(level), MAX_LEVEL);
    check("won_points", int'(points), 64);
    check("won_level_up_count", lu_dut - lu_start, MAX_LEVEL - 1);

    // End state: start returns to IDLE values, a second start resumes play.
    cycle(1'b1, 1'b0, 1'b0);
    check("end_idle_level", int'(level), 1);
    check("end_idle_points", int'(points), 0);
    check("end_idle_won", int'(game_won), 0);
    check("end_idle_playing", int'(playing), 0);
    cycle(1'b1, 1'b0, 1'b0);
    check("end_restart_playing", int'(playing), 1);

    // Simultaneous hit and miss: the miss wins.
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b0);
    cycle(1'b0, 1'b1, 1'b1);
    check("hitmiss_points", int'(points), 3);
`ifdef SCORE_LIVES_EN
    check("miss1_lives", int'(lives), 2);
    check("miss1_playing", int'(playing), 1);
    cycle(1'b0, 1'b0, 1'b1);
    check("miss2_lives", int'(lives), 1);
    cycle(1'b0, 1'b0, 1'b1);
    check("miss3_lives", int'(lives), 0);
    check("miss3_game_over", int'(game_over), 1);
`else
    check("miss_game_over", int'(game_over), 1);
    check("miss_lives_const", int'(lives), 3);
`endif
    cycle(1'b0, 1'b1, 1'b0);
    check("lost_points_frozen", int'(points), 3);
    cycle(1'b1, 1'b0, 1'b0);
    check("lost_idle_level", int'(level), 1);
    check("lost_idle_game_over", int'(game_over), 0);
    cycle(1'b1, 1'b0, 1'b0);
    check("lost_restart_playing", int'(playing), 1);

    // Climb to level 5 and reset in the middle of the pause.
    n = 0;
    while (!(m_mode == G_PAUSE && m_level == 5) && n < 2000) begin
      cycle(1'b0, 1'b1, 1'b0);
      n++;
    end
    check("pause_l5_level", int'(level), 5);
    check("pause_l5_points", int'(points), 32);
    check("pause_l5_playing", int'(playing), 0);
    do_reset();

    // Random mix of start, hit and miss pulses.
    for (int i = 0; i < 800; i++) begin
      cycle($urandom_range(0, 99) < 4, $urandom_range(0, 99) < 55, $urandom_range(0, 99) < 3);
    end
    repeat (3) cycle(1'b0, 1'b0, 1'b0);

    @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    check("level_up_total", lu_dut, lu_model);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/score_keeper.md
# score_keeper

Game-progress controller that sits directly upstream of the level parameter table. It counts correct player responses, compares the cumulative score against the table's `max_points` threshold and advances `level`. It enforces an inter-level pause and tracks misses and lives, ending the game in a won or lost state. Its `level` output drives the table; the table's `max_points` output feeds back into this block.

## Interface
- `MAX_LEVEL`, 8: final level; reaching its threshold wins the game.
- `PAUSE_CYCLES`, 100000000: cycles spent in the inter-level pause; must be ≥ 2.
- `LIVES`, 3: starting lives, range 1–3; used only with `SCORE_LIVES_EN`.

Ports:
- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  single-cycle pulse; begins a game or returns from an end state.
- `hit`  in  1  single-cycle pulse; correct player response.
- `miss`  in  1  single-cycle pulse; wrong response or timeout.
- `max_points`  in  32  cumulative score threshold for the current level, from the level table.
- `level`  out  4  current level, 1..MAX_LEVEL.
- `points`  out  32  cumulative score.
- `lives`  out  2  remaining lives.
- `playing`  out  1  high while in PLAY.
- `level_up`  out  1  one-cycle pulse on each level advance.
- `game_won`  out  1  high in WON.
- `game_over`  out  1  high in LOST.

## Operation
- States: IDLE, PLAY, PAUSE, WON, LOST. All outputs are registered.
- Reset values: state IDLE, `level`=1, `points`=0, `lives`=LIVES (3 when the macro is off), all flags 0.
- IDLE: holds reset values.
  - `start` → PLAY.
  - `hit`/`miss` ignored.
- PLAY, `hit` without `miss`: `points` ← `points`+1. Then, if `points`+1 ≥ `max_points`:
  - `level`==MAX_LEVEL → WON; `level` unchanged.
  - otherwise `level` ← `level`+1, pulse `level_up`, → PAUSE with the pause counter cleared.
- PLAY, `miss` (also when asserted together with `hit`): the `hit` is discarded.
  - `lives` handling is described under Configuration.
- PAUSE: counter increments every cycle; `hit`, `miss` and `start` are ignored. When the counter reaches PAUSE_CYCLES−1 → PLAY.
- WON and LOST: all counters hold.
  - `start` → IDLE with reset values reloaded.
  - `hit`/`miss` ignored.
- `start` in PLAY or PAUSE is ignored.
- Threshold comparison is 32-bit unsigned `>=`. `points` cannot overflow, since the maximum threshold is 64.
- The level table registers its outputs, so `max_points` lags `level` by one cycle. PAUSE_CYCLES ≥ 2 guarantees `max_points` is settled before PLAY resumes.
- After an end state, IDLE re-drives `level`=1 before the next `start`.

## Timing
- A `hit` sampled at edge N updates `points` at edge N. The new `level`, the `level_up` pulse and the state change appear at that same edge, visible in cycle N+1.
- `level_up` is high for exactly one cycle.
- PAUSE lasts exactly PAUSE_CYCLES cycles. `playing` is low for exactly PAUSE_CYCLES cycles, then rises.
- `start` → `playing`=1 in the following cycle.
- `miss` → `lives` decrement or LOST, visible the following cycle.
- Reset asserted mid-game forces reset values immediately; there is no clock dependency.

## Configuration
- `SCORE_LIVES_EN` defined:
  - A `miss` in PLAY with `lives` > 1 decrements `lives` and stays in PLAY.
  - A `miss` with `lives`==1 sets `lives`=0 → LOST.
- `SCORE_LIVES_EN` undefined:
  - Any `miss` in PLAY → LOST.
  - `lives` is held at constant 3 and the LIVES parameter is unused.

## Test plan
- Reset, then `start`, then 8 `hit` pulses with `max_points`=8 → `points`=8, `level`=2, one `level_up` pulse, `playing` low for PAUSE_CYCLES (2 in sim).
- Full run, with table attached, through 64 hits and ignoring hits during PAUSE → `game_won`=1, `level`=8, `points`=64, exactly 7 `level_up` pulses.
- `SCORE_LIVES_EN`, LIVES=3, three `miss` pulses → `lives` 2, 1, 0; `game_over`=1 after the third miss.
- Without the macro, one `miss` → `game_over`=1, `points` frozen.
- `hit` and `miss` in the same cycle → `points` unchanged, miss processed. A `hit` during PAUSE → `points` unchanged.
- `rst_n` low mid-PAUSE with `level`=5 → immediately `level`=1, `points`=0, IDLE. After `game_over`, `start` → IDLE values, and a second `start` → PLAY.
